// File: rtl/quasar_pkg.sv
// Shared types and helpers for the state-vector gate sequencers.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

package quasar_pkg;

    // Default width of one real or imaginary fixed-point component.
    localparam int FIXED_W = `FIXED_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CAP  = 3'd3,
        WR0  = 3'd4,
        WR1  = 3'd5,
        DONE = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [FIXED_W-1:0] re;
        logic [FIXED_W-1:0] im;
    } cplx_t;

    // Address of the |0> member of pair k when the target qubit is t:
    // insert a zero bit at position t into k.
    function automatic logic [31:0] pair_addr(input logic [31:0] k, input logic [31:0] t);
        logic [31:0] low_mask;
        low_mask = (32'd1 << t) - 32'd1;
        return ((k >> t) << (t + 32'd1)) | (k & low_mask);
    endfunction

endpackage

// File: rtl/pair_index_gen.sv
// Maps a pair counter and target qubit index to the two amplitude addresses
// that differ only in the target bit.
module pair_index_gen
    import quasar_pkg::*;
#(
    parameter int NUM_QUBITS = 4,
    parameter int TGT_W      = 3
) (
    input  logic [NUM_QUBITS-2:0] k,
    input  logic [TGT_W-1:0]      t,
    output logic [NUM_QUBITS-1:0] a0,
    output logic [NUM_QUBITS-1:0] a1
);

    // Zero-insert for a0, then set the target bit for a1.
    always_comb begin
        a0 = NUM_QUBITS'(pair_addr(32'(k), 32'(t)));
        a1 = a0 | NUM_QUBITS'(32'd1 << t);
    end

endmodule

// File: rtl/qubit_pair_sequencer.sv
// Walks every amplitude pair for one target qubit: reads both amplitudes,
// presents them to the combinational gate stage, writes the results back.
module qubit_pair_sequencer
    import quasar_pkg::*;
#(
    parameter int NUM_QUBITS = 4,
    parameter int DATA_W     = FIXED_W,
    // One extra bit so that out-of-range target indices can be presented and flagged.
    parameter int TGT_W      = $clog2(NUM_QUBITS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TGT_W-1:0]      target,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_ren,
    output logic [NUM_QUBITS-1:0] mem_raddr,
    input  logic [DATA_W-1:0]     mem_rd_re,
    input  logic [DATA_W-1:0]     mem_rd_im,
    output logic                  mem_wen,
    output logic [NUM_QUBITS-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wr_re,
    output logic [DATA_W-1:0]     mem_wr_im,
    output logic [DATA_W-1:0]     g0_re,
    output logic [DATA_W-1:0]     g0_im,
    output logic [DATA_W-1:0]     g1_re,
    output logic [DATA_W-1:0]     g1_im,
    input  logic [DATA_W-1:0]     r0_re,
    input  logic [DATA_W-1:0]     r0_im,
    input  logic [DATA_W-1:0]     r1_re,
    input  logic [DATA_W-1:0]     r1_im
);

    localparam int                K_W        = NUM_QUBITS - 1;
    localparam logic [K_W-1:0]    K_LAST     = {K_W{1'b1}};
    localparam logic [TGT_W-1:0]  TGT_LIMIT  = TGT_W'(NUM_QUBITS);

    seq_state_e                state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [TGT_W-1:0]          tgt_q, tgt_d;
    logic [DATA_W-1:0]         x0_re_q, x0_re_d, x0_im_q, x0_im_d;
    logic [DATA_W-1:0]         y1_re_q, y1_re_d, y1_im_q, y1_im_d;
    // The g1 registers double as the x1 capture: they load straight from read data.
    logic [DATA_W-1:0]         g0_re_q, g0_re_d, g0_im_q, g0_im_d;
    logic [DATA_W-1:0]         g1_re_q, g1_re_d, g1_im_q, g1_im_d;
    logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                      ren_q, ren_d, wen_q, wen_d;
    logic [NUM_QUBITS-1:0]     raddr_q, raddr_d, waddr_q, waddr_d;
    logic [NUM_QUBITS-1:0]     a0_s, a1_s;

    // Addresses for the pair the FSM will be working on next cycle.
    pair_index_gen #(
        .NUM_QUBITS (NUM_QUBITS),
        .TGT_W      (TGT_W)
    ) u_pair_index_gen (
        .k  (k_d),
        .t  (tgt_d),
        .a0 (a0_s),
        .a1 (a1_s)
    );

    // Next-state, counter and datapath capture logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tgt_d   = tgt_q;
        x0_re_d = x0_re_q;
        x0_im_d = x0_im_q;
        y1_re_d = y1_re_q;
        y1_im_d = y1_im_q;
        g0_re_d = g0_re_q;
        g0_im_d = g0_im_q;
        g1_re_d = g1_re_q;
        g1_im_d = g1_im_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d = target;
                    k_d   = '0;
                    if (target >= TGT_LIMIT) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RD0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD0: state_d = RD1;
            RD1: begin
                x0_re_d = mem_rd_re;
                x0_im_d = mem_rd_im;
                state_d = CAP;
            end
            CAP: begin
                g0_re_d = x0_re_q;
                g0_im_d = x0_im_q;
                g1_re_d = mem_rd_re;
                g1_im_d = mem_rd_im;
                state_d = WR0;
            end
            WR0: begin
                y1_re_d = r1_re;
                y1_im_d = r1_im;
                state_d = WR1;
            end
            WR1: begin
                if (k_q != K_LAST) begin
                    k_d     = k_q + K_W'(1);
                    state_d = RD0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output register values derived from the upcoming state.
    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        ren_d   = (state_d == RD0) || (state_d == RD1);
        wen_d   = (state_d == WR0) || (state_d == WR1);
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        case (state_d)
            RD0:     raddr_d = a0_s;
            RD1:     raddr_d = a1_s;
            WR0:     waddr_d = a0_s;
            WR1:     waddr_d = a1_s;
            default: raddr_d = raddr_q;
        endcase
    end

    // Write data: gate result for a0 is used live, a1 result comes from its latch.
    always_comb begin
        case (state_q)
            WR0: begin
                mem_wr_re = r0_re;
                mem_wr_im = r0_im;
            end
            WR1: begin
                mem_wr_re = y1_re_q;
                mem_wr_im = y1_im_q;
            end
            default: begin
                mem_wr_re = '0;
                mem_wr_im = '0;
            end
        endcase
    end

    // State, counter, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            tgt_q   <= '0;
            x0_re_q <= '0;
            x0_im_q <= '0;
            y1_re_q <= '0;
            y1_im_q <= '0;
            g0_re_q <= '0;
            g0_im_q <= '0;
            g1_re_q <= '0;
            g1_im_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tgt_q   <= tgt_d;
            x0_re_q <= x0_re_d;
            x0_im_q <= x0_im_d;
            y1_re_q <= y1_re_d;
            y1_im_q <= y1_im_d;
            g0_re_q <= g0_re_d;
            g0_im_q <= g0_im_d;
            g1_re_q <= g1_re_d;
            g1_im_q <= g1_im_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_ren   = ren_q;
    assign mem_raddr = raddr_q;
    assign mem_wen   = wen_q;
    assign mem_waddr = waddr_q;
    assign g0_re     = g0_re_q;
    assign g0_im     = g0_im_q;
    assign g1_re     = g1_re_q;
    assign g1_im     = g1_im_q;

endmodule

// File: tb/tb_qubit_pair_sequencer.sv
// Directed bench for qubit_pair_sequencer with a 4-entry state RAM and a
// selectable swap / identity gate.
module tb_qubit_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  target;
    logic        busy, done, err;
    logic        mem_ren, mem_wen;
    logic [1:0]  mem_raddr, mem_waddr;
    logic [15:0] mem_rd_re, mem_rd_im, mem_wr_re, mem_wr_im;
    logic [15:0] g0_re, g0_im, g1_re, g1_im;
    logic [15:0] r0_re, r0_im, r1_re, r1_im;

    logic        gate_id;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [15:0] ld_re, ld_im;
    logic [15:0] mem_re [4];
    logic [15:0] mem_im [4];

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] rnd_re, rnd_im;

    always #5 clk = ~clk;

    qubit_pair_sequencer #(.NUM_QUBITS(2), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .busy(busy), .done(done), .err(err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rd_re(mem_rd_re), .mem_rd_im(mem_rd_im),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wr_re(mem_wr_re), .mem_wr_im(mem_wr_im),
        .g0_re(g0_re), .g0_im(g0_im), .g1_re(g1_re), .g1_im(g1_im),
        .r0_re(r0_re), .r0_im(r0_im), .r1_re(r1_re), .r1_im(r1_im)
    );

    // Gate: swap (pauli_x style) or identity.
    assign r0_re = gate_id ? g0_re : g1_re;
    assign r0_im = gate_id ? g0_im : g1_im;
    assign r1_re = gate_id ? g1_re : g0_re;
    assign r1_im = gate_id ? g1_im : g0_im;

    // Synchronous state RAM with a bench-side load port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem_re[ld_addr] <= ld_re;
            mem_im[ld_addr] <= ld_im;
        end
        if (mem_ren) begin
            mem_rd_re <= mem_re[mem_raddr];
            mem_rd_im <= mem_im[mem_raddr];
        end
        if (mem_wen) begin
            mem_re[mem_waddr] <= mem_wr_re;
            mem_im[mem_waddr] <= mem_wr_im;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [63:0] re_v, input logic [63:0] im_v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 2'(i);
            ld_re   = re_v[i*16 +: 16];
            ld_im   = im_v[i*16 +: 16];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic [63:0] re_v, input logic [63:0] im_v);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_re[%0d]", tag, i), 32'(mem_re[i]), 32'(re_v[i*16 +: 16]));
            chk($sformatf("%s_im[%0d]", tag, i), 32'(mem_im[i]), 32'(im_v[i*16 +: 16]));
        end
    endtask

    // One pass: start sampled in cycle 0, every cycle 1..14 checked mid-cycle.
    task automatic run_pass(input string tag, input logic [1:0] tgt, input bit invalid, input bit extra);
        int dn, ph, pr;
        logic [1:0] a0, a1;
        logic e_ren, e_wen;
        dn = invalid ? 1 : 11;
        @(negedge clk);
        start  = 1'b1;
        target = tgt;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = extra && (n == 3 || n == 11);
            ph = (n - 1) % 5;
            pr = (n - 1) / 5;
            a0 = (tgt == 2'd0) ? 2'(2 * pr) : 2'(pr);
            a1 = (tgt == 2'd0) ? 2'(2 * pr + 1) : 2'(pr + 2);
            e_ren = !invalid && n <= 10 && ph < 2;
            e_wen = !invalid && n <= 10 && ph >= 3;
            chk($sformatf("%s_busy_c%0d", tag, n), 32'(busy), 32'(n <= dn));
            chk($sformatf("%s_done_c%0d", tag, n), 32'(done), 32'(n == dn));
            chk($sformatf("%s_err_c%0d", tag, n), 32'(err), 32'(invalid && n == dn));
            chk($sformatf("%s_ren_c%0d", tag, n), 32'(mem_ren), 32'(e_ren));
            chk($sformatf("%s_wen_c%0d", tag, n), 32'(mem_wen), 32'(e_wen));
            if (e_ren)
                chk($sformatf("%s_raddr_c%0d", tag, n), 32'(mem_raddr), 32'((ph == 0) ? a0 : a1));
            if (e_wen)
                chk($sformatf("%s_waddr_c%0d", tag, n), 32'(mem_waddr), 32'((ph == 3) ? a0 : a1));
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; target = 2'd0; gate_id = 1'b0;
        ld_en = 1'b0; ld_addr = 2'd0; ld_re = 16'd0; ld_im = 16'd0;

        // Reset values.
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ren", 32'(mem_ren), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_raddr", 32'(mem_raddr), 32'd0);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_wdata", {mem_wr_re, mem_wr_im}, 32'd0);
        chk("rst_g0", {g0_re, g0_im}, 32'd0);
        chk("rst_g1", {g1_re, g1_im}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1) swap, target 0.
        load_mem({16'd0, 16'd0, 16'd0, 16'd1}, 64'd0);
        run_pass("t1", 2'd0, 1'b0, 1'b0);
        check_mem("t1", {16'd0, 16'd0, 16'd1, 16'd0}, 64'd0);

        // 2) swap, target 1, write order 0,2,1,3.
        load_mem({16'd0, 16'd0, 16'd0, 16'd1}, 64'd0);
        run_pass("t2", 2'd1, 1'b0, 1'b0);
        check_mem("t2", {16'd0, 16'd1, 16'd0, 16'd0}, 64'd0);

        // 3) invalid target: immediate done+err, memory untouched.
        run_pass("t3", 2'd2, 1'b1, 1'b0);
        check_mem("t3", {16'd0, 16'd1, 16'd0, 16'd0}, 64'd0);

        // 4) extra start pulses in cycles 3 and 11 are ignored.
        load_mem({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5});
        run_pass("t4", 2'd0, 1'b0, 1'b1);
        check_mem("t4", {16'd3, 16'd4, 16'd1, 16'd2}, {16'd7, 16'd8, 16'd5, 16'd6});

        // 5) reset asserted early in cycle 6, then a clean pass.
        @(negedge clk);
        start = 1'b1; target = 2'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("t5_pre_ren", 32'(mem_ren), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ren", 32'(mem_ren), 32'd0);
        chk("t5_wen", 32'(mem_wen), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_mem({16'd40, 16'd30, 16'd20, 16'd10}, {16'd4, 16'd3, 16'd2, 16'd1});
        run_pass("t5", 2'd1, 1'b0, 1'b0);
        check_mem("t5", {16'd20, 16'd10, 16'd40, 16'd30}, {16'd2, 16'd1, 16'd4, 16'd3});

        // 6) identity gate on random data, both targets; gate inputs hold afterwards.
        gate_id = 1'b1;
        rnd_re = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        rnd_im = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        load_mem(rnd_re, rnd_im);
        run_pass("t6a", 2'd0, 1'b0, 1'b0);
        check_mem("t6a", rnd_re, rnd_im);
        run_pass("t6b", 2'd1, 1'b0, 1'b0);
        check_mem("t6b", rnd_re, rnd_im);
        chk("t6_g0_hold", {g0_re, g0_im}, {rnd_re[31:16], rnd_im[31:16]});
        chk("t6_g1_hold", {g1_re, g1_im}, {rnd_re[63:48], rnd_im[63:48]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
